// File: rtl/npu_job_scheduler.sv
// Job FIFO and launch/run/complete sequencer in front of a single systolic array.
// Runs one job at a time and returns one completion record per job to the host.
module npu_job_scheduler #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned AW      = 12,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [AW-1:0]              job_addr_A,
  input  logic [AW-1:0]              job_addr_B,
  input  logic [AW-1:0]              job_addr_C,
  input  logic [3:0]                 job_n,
  input  logic                       abort,
  output logic                       arr_new_data,
  output logic [AW-1:0]              arr_addr_A,
  output logic [AW-1:0]              arr_addr_B,
  output logic [AW-1:0]              arr_addr_C,
  output logic [3:0]                 arr_n,
  input  logic                       arr_done,
  input  logic                       arr_overflow,
  output logic                       cpl_valid,
  input  logic                       cpl_ready,
  output logic [AW-1:0]              cpl_addr_C,
  output logic                       cpl_overflow,
  output logic                       cpl_timeout,
  output logic [15:0]                cpl_cycles,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] queue_count,
  output logic [31:0]                jobs_done
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned QW = $clog2(DEPTH + 1);
  // Run counter is wide enough for TIMEOUT and for detecting 16-bit saturation.
  localparam int unsigned CW = ($clog2(TIMEOUT + 1) >= 17) ? $clog2(TIMEOUT + 1) + 1 : 17;

  typedef struct packed {
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [AW-1:0] addr_c;
    logic [3:0]    n;
  } job_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_COMPLETE,
    S_DRAIN
  } state_t;

  job_t          mem [DEPTH];
  job_t          in_job;
  job_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  state_t        state;
  logic [CW-1:0] run_cnt;
  logic [CW-1:0] run_inc;
  logic          push;
  logic          pop;
  logic          timeout_hit;
  logic [15:0]   cyc_sat;

  // Ready deliberately ignores a same-cycle pop: a full FIFO always stalls.
  assign job_ready   = (queue_count < QW'(DEPTH)) && !abort;
  assign push        = job_valid && job_ready;
  assign pop         = (state == S_IDLE) && (queue_count != '0) && !cpl_valid && !abort;
  assign in_job      = '{job_addr_A, job_addr_B, job_addr_C, job_n};
  assign head        = mem[rd_ptr];
  assign run_inc     = run_cnt + CW'(1);
  assign timeout_hit = (run_inc == CW'(TIMEOUT));
  assign cyc_sat     = (run_inc > CW'(16'hFFFF)) ? 16'hFFFF : run_inc[15:0];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_job;
  end

  // FIFO pointers and occupancy; abort empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
    end else if (abort) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      queue_count <= queue_count + QW'(push) - QW'(pop);
    end
  end

  // Job sequencer with registered array and completion outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      run_cnt      <= '0;
      arr_new_data <= 1'b0;
      arr_addr_A   <= '0;
      arr_addr_B   <= '0;
      arr_addr_C   <= '0;
      arr_n        <= '0;
      cpl_valid    <= 1'b0;
      cpl_addr_C   <= '0;
      cpl_overflow <= 1'b0;
      cpl_timeout  <= 1'b0;
      cpl_cycles   <= '0;
      jobs_done    <= '0;
    end else begin
      arr_new_data <= 1'b0;
      if (abort) begin
        cpl_valid <= 1'b0;
        if (state == S_RUN || state == S_LAUNCH) begin
          state   <= S_DRAIN;
          busy    <= 1'b1;
          run_cnt <= '0;
        end else begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (pop) begin
              arr_addr_A   <= head.addr_a;
              arr_addr_B   <= head.addr_b;
              arr_addr_C   <= head.addr_c;
              arr_n        <= head.n;
              arr_new_data <= 1'b1;
              busy         <= 1'b1;
              state        <= S_LAUNCH;
            end
          end
          S_LAUNCH: begin
            run_cnt <= '0;
            state   <= S_RUN;
          end
          S_RUN: begin
            run_cnt <= run_inc;
            if (arr_done || timeout_hit) begin
              cpl_valid    <= 1'b1;
              cpl_addr_C   <= arr_addr_C;
              cpl_cycles   <= cyc_sat;
              cpl_overflow <= arr_done ? arr_overflow : 1'b0;
              cpl_timeout  <= !arr_done;
              state        <= S_COMPLETE;
            end
          end
          S_COMPLETE: begin
            if (cpl_ready) begin
              cpl_valid <= 1'b0;
              jobs_done <= jobs_done + 32'd1;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end
          end
          S_DRAIN: begin
            run_cnt <= run_inc;
            if (arr_done || timeout_hit) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_npu_job_scheduler.sv
// Randomized self-checking bench for npu_job_scheduler against a queue-based job model.
module tb_npu_job_scheduler;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 12;
  localparam int unsigned TOUT  = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [AW-1:0] job_addr_A = '0;
  logic [AW-1:0] job_addr_B = '0;
  logic [AW-1:0] job_addr_C = '0;
  logic [3:0]    job_n = '0;
  logic          abort = 1'b0;
  logic          arr_new_data;
  logic [AW-1:0] arr_addr_A;
  logic [AW-1:0] arr_addr_B;
  logic [AW-1:0] arr_addr_C;
  logic [3:0]    arr_n;
  logic          arr_done = 1'b0;
  logic          arr_overflow = 1'b0;
  logic          cpl_valid;
  logic          cpl_ready = 1'b0;
  logic [AW-1:0] cpl_addr_C;
  logic          cpl_overflow;
  logic          cpl_timeout;
  logic [15:0]   cpl_cycles;
  logic          busy;
  logic [2:0]    queue_count;
  logic [31:0]   jobs_done;

  typedef struct {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW-1:0] c;
    logic [3:0]    n;
  } job_s;

  job_s        mq[$];
  int          vectors = 0;
  int          errors = 0;
  int unsigned jobs_model = 0;

  npu_job_scheduler #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_addr_A(job_addr_A), .job_addr_B(job_addr_B), .job_addr_C(job_addr_C), .job_n(job_n),
    .abort(abort), .arr_new_data(arr_new_data), .arr_addr_A(arr_addr_A),
    .arr_addr_B(arr_addr_B), .arr_addr_C(arr_addr_C), .arr_n(arr_n), .arr_done(arr_done),
    .arr_overflow(arr_overflow), .cpl_valid(cpl_valid), .cpl_ready(cpl_ready),
    .cpl_addr_C(cpl_addr_C), .cpl_overflow(cpl_overflow), .cpl_timeout(cpl_timeout),
    .cpl_cycles(cpl_cycles), .busy(busy), .queue_count(queue_count), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic job_s rand_job();
    job_s j;
    j.a = AW'($urandom);
    j.b = AW'($urandom);
    j.c = AW'($urandom);
    j.n = 4'($urandom_range(1, 15));
    return j;
  endfunction

  task automatic drive_job(input job_s j);
    job_addr_A = j.a;
    job_addr_B = j.b;
    job_addr_C = j.c;
    job_n      = j.n;
  endtask

  task automatic push_one(input job_s j);
    drive_job(j);
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
  endtask

  task automatic wait_launch(output int lat);
    lat = -1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (arr_new_data === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  // Array answers d RUN edges after the launch pulse.
  task automatic run_array(input int d, input logic ovf);
    for (int i = 1; i < d; i++) tick();
    arr_done     = 1'b1;
    arr_overflow = ovf;
    tick();
    arr_done     = 1'b0;
    arr_overflow = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    job_valid = 1'b1;
    tick();
    tick();
    vectors++;
    if ({busy, arr_new_data, cpl_valid, cpl_timeout, cpl_overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000", {busy, arr_new_data, cpl_valid, cpl_timeout, cpl_overflow});
    end
    vectors++;
    if ({queue_count, jobs_done, cpl_cycles} !== '0) begin
      errors++;
      $display("FAIL reset_counts: got q=%0d jobs=%0d cyc=%0d want 0", queue_count, jobs_done, cpl_cycles);
    end
    vectors++;
    if ({arr_addr_A, arr_addr_B, arr_addr_C, arr_n, cpl_addr_C} !== '0) begin
      errors++;
      $display("FAIL reset_addrs: got nonzero want 0");
    end
    job_valid = 1'b0;
    rst = 1'b0;
    tick();
    vectors++;
    if (job_ready !== 1'b1 || queue_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b q=%0d want ready=1 q=0", job_ready, queue_count);
    end
  endtask

  task automatic test_single();
    job_s j;
    int   lat;
    j.a = 12'd0; j.b = 12'd16; j.c = 12'd32; j.n = 4'd4;
    push_one(j);
    vectors++;
    if (queue_count !== 3'd1 || arr_new_data !== 1'b0) begin
      errors++;
      $display("FAIL single_push: got q=%0d nd=%b want q=1 nd=0", queue_count, arr_new_data);
    end
    wait_launch(lat);
    vectors++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL single_latency: got %0d want 1", lat);
    end
    vectors++;
    if ({arr_addr_A, arr_addr_B, arr_addr_C, arr_n} !== {j.a, j.b, j.c, j.n}) begin
      errors++;
      $display("FAIL single_arr: got %h %h %h %h want %h %h %h %h", arr_addr_A, arr_addr_B, arr_addr_C, arr_n, j.a, j.b, j.c, j.n);
    end
    tick();
    vectors++;
    if (arr_new_data !== 1'b0 || busy !== 1'b1 || queue_count !== 3'd0) begin
      errors++;
      $display("FAIL single_pulse: got nd=%b busy=%b q=%0d want 0 1 0", arr_new_data, busy, queue_count);
    end
    run_array(20, 1'b0);
    vectors++;
    if ({cpl_valid, cpl_addr_C, cpl_cycles, cpl_timeout, cpl_overflow} !== {1'b1, 12'd32, 16'd20, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_cpl: got v=%b c=%0d cyc=%0d to=%b of=%b want 1 32 20 0 0", cpl_valid, cpl_addr_C, cpl_cycles, cpl_timeout, cpl_overflow);
    end
    cpl_ready = 1'b1;
    tick();
    cpl_ready = 1'b0;
    jobs_model++;
    vectors++;
    if (jobs_done !== jobs_model || cpl_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_handshake: got jobs=%0d v=%b want %0d 0", jobs_done, cpl_valid, jobs_model);
    end
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    job_s j;
    job_s j0;
    int   lat;
    int   d;
    logic exp_ready;
    j0 = rand_job();
    push_one(j0);
    wait_launch(lat);
    tick();
    run_array(5, 1'b0);
    // Completion held: nothing pops, so the FIFO fills to DEPTH.
    for (int k = 0; k < 5; k++) begin
      j = rand_job();
      drive_job(j);
      job_valid = 1'b1;
      exp_ready = (mq.size() < DEPTH);
      vectors++;
      if (job_ready !== exp_ready) begin
        errors++;
        $display("FAIL b2b_ready%0d: got %b want %b", k, job_ready, exp_ready);
      end
      tick();
      if (exp_ready) mq.push_back(j);
    end
    job_valid = 1'b0;
    vectors++;
    if (queue_count !== 3'(DEPTH) || job_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full: got q=%0d ready=%b want 4 0", queue_count, job_ready);
    end
    for (int c = 0; c < 50; c++) begin
      vectors++;
      if ({arr_new_data, cpl_valid, cpl_addr_C, cpl_cycles} !== {1'b0, 1'b1, j0.c, 16'd5}) begin
        errors++;
        $display("FAIL hold_cpl%0d: got nd=%b v=%b c=%h cyc=%0d want 0 1 %h 5", c, arr_new_data, cpl_valid, cpl_addr_C, cpl_cycles, j0.c);
      end
      tick();
    end
    cpl_ready = 1'b1;
    tick();
    cpl_ready = 1'b0;
    jobs_model++;
    while (mq.size() > 0) begin
      wait_launch(lat);
      vectors++;
      if (lat !== 1 || {arr_addr_A, arr_addr_B, arr_addr_C, arr_n} !== {mq[0].a, mq[0].b, mq[0].c, mq[0].n}) begin
        errors++;
        $display("FAIL b2b_order: got lat=%0d c=%h want lat=1 c=%h", lat, arr_addr_C, mq[0].c);
      end
      j = mq.pop_front();
      tick();
      d = int'($urandom_range(1, 12));
      run_array(d, 1'b0);
      vectors++;
      if (cpl_valid !== 1'b1 || cpl_cycles !== 16'(d) || cpl_addr_C !== j.c) begin
        errors++;
        $display("FAIL b2b_cpl: got v=%b cyc=%0d c=%h want 1 %0d %h", cpl_valid, cpl_cycles, cpl_addr_C, d, j.c);
      end
      cpl_ready = 1'b1;
      tick();
      cpl_ready = 1'b0;
      jobs_model++;
    end
    vectors++;
    if (jobs_done !== jobs_model) begin
      errors++;
      $display("FAIL b2b_jobs: got %0d want %0d", jobs_done, jobs_model);
    end
  endtask

  task automatic test_timeout();
    job_s j;
    int   lat;
    int   n;
    j = rand_job();
    push_one(j);
    wait_launch(lat);
    tick();
    arr_overflow = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      n++;
      if (cpl_valid === 1'b1) break;
    end
    arr_overflow = 1'b0;
    vectors++;
    if (n !== int'(TOUT) || {cpl_valid, cpl_timeout, cpl_overflow, cpl_cycles, cpl_addr_C} !== {1'b1, 1'b1, 1'b0, 16'(TOUT), j.c}) begin
      errors++;
      $display("FAIL timeout_cpl: got n=%0d v=%b to=%b of=%b cyc=%0d want %0d 1 1 0 %0d", n, cpl_valid, cpl_timeout, cpl_overflow, cpl_cycles, TOUT, TOUT);
    end
    arr_done = 1'b1;
    tick();
    arr_done = 1'b0;
    vectors++;
    if (cpl_timeout !== 1'b1 || cpl_valid !== 1'b1) begin
      errors++;
      $display("FAIL late_done_ignored: got to=%b v=%b want 1 1", cpl_timeout, cpl_valid);
    end
    cpl_ready = 1'b1;
    tick();
    cpl_ready = 1'b0;
    jobs_model++;
    j = rand_job();
    push_one(j);
    wait_launch(lat);
    tick();
    run_array(7, 1'b1);
    vectors++;
    if ({lat, cpl_timeout, cpl_overflow, cpl_cycles} !== {32'sd1, 1'b0, 1'b1, 16'd7}) begin
      errors++;
      $display("FAIL post_timeout_job: got lat=%0d to=%b of=%b cyc=%0d want 1 0 1 7", lat, cpl_timeout, cpl_overflow, cpl_cycles);
    end
    cpl_ready = 1'b1;
    tick();
    cpl_ready = 1'b0;
    jobs_model++;
  endtask

  task automatic test_abort();
    int lat;
    int w;
    push_one(rand_job());
    wait_launch(lat);
    tick();
    for (int k = 0; k < 3; k++) push_one(rand_job());
    vectors++;
    if (queue_count !== 3'd3) begin
      errors++;
      $display("FAIL abort_queued: got %0d want 3", queue_count);
    end
    for (int i = 0; i < int'($urandom_range(0, 4)); i++) tick();
    abort = 1'b1;
    job_valid = 1'b1;
    #1;
    vectors++;
    if (job_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_ready: got %b want 0", job_ready);
    end
    tick();
    abort = 1'b0;
    job_valid = 1'b0;
    vectors++;
    if ({queue_count, cpl_valid, busy, arr_new_data} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL abort_drain: got q=%0d v=%b busy=%b nd=%b want 0 0 1 0", queue_count, cpl_valid, busy, arr_new_data);
    end
    w = int'($urandom_range(3, 40));
    for (int i = 0; i < w; i++) begin
      tick();
      vectors++;
      if (cpl_valid !== 1'b0 || arr_new_data !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL drain_wait%0d: got v=%b nd=%b busy=%b want 0 0 1", i, cpl_valid, arr_new_data, busy);
      end
    end
    arr_done = 1'b1;
    tick();
    arr_done = 1'b0;
    tick();
    tick();
    vectors++;
    if ({busy, cpl_valid, arr_new_data} !== 3'b000 || jobs_done !== jobs_model) begin
      errors++;
      $display("FAIL abort_end: got busy=%b v=%b nd=%b jobs=%0d want 0 0 0 %0d", busy, cpl_valid, arr_new_data, jobs_done, jobs_model);
    end
  endtask

  task automatic test_random();
    job_s j;
    int   lat;
    int   d;
    logic ovf;
    mq.push_back(rand_job());
    push_one(mq[$]);
    for (int it = 0; it < 8; it++) begin
      wait_launch(lat);
      j = mq.pop_front();
      vectors++;
      if (lat !== 1 || {arr_addr_A, arr_addr_B, arr_addr_C, arr_n} !== {j.a, j.b, j.c, j.n}) begin
        errors++;
        $display("FAIL rand_launch%0d: got lat=%0d c=%h want 1 %h", it, lat, arr_addr_C, j.c);
      end
      tick();
      d = int'($urandom_range(1, 120));
      ovf = 1'($urandom);
      run_array(d, ovf);
      if (it < 7 && ($urandom % 2) == 0) begin
        mq.push_back(rand_job());
        push_one(mq[$]);
      end
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
      vectors++;
      if (d <= int'(TOUT)) begin
        if ({cpl_valid, cpl_addr_C, cpl_cycles, cpl_timeout, cpl_overflow} !== {1'b1, j.c, 16'(d), 1'b0, ovf}) begin
          errors++;
          $display("FAIL rand_cpl%0d: got cyc=%0d to=%b of=%b want %0d 0 %b", it, cpl_cycles, cpl_timeout, cpl_overflow, d, ovf);
        end
      end else begin
        if ({cpl_valid, cpl_addr_C, cpl_cycles, cpl_timeout, cpl_overflow} !== {1'b1, j.c, 16'(TOUT), 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL rand_tout%0d: got cyc=%0d to=%b of=%b want %0d 1 0", it, cpl_cycles, cpl_timeout, cpl_overflow, TOUT);
        end
      end
      cpl_ready = 1'b1;
      tick();
      cpl_ready = 1'b0;
      jobs_model++;
      vectors++;
      if (jobs_done !== jobs_model) begin
        errors++;
        $display("FAIL rand_jobs%0d: got %0d want %0d", it, jobs_done, jobs_model);
      end
      if (mq.size() == 0 && it < 7) begin
        mq.push_back(rand_job());
        push_one(mq[$]);
      end
    end
  endtask

  task automatic test_overflow_reset();
    job_s j;
    int   lat;
    j = rand_job();
    j.c = 12'hABC;
    push_one(j);
    wait_launch(lat);
    tick();
    run_array(3, 1'b1);
    vectors++;
    if (cpl_overflow !== 1'b1 || cpl_cycles !== 16'd3) begin
      errors++;
      $display("FAIL overflow_flag: got of=%b cyc=%0d want 1 3", cpl_overflow, cpl_cycles);
    end
    cpl_ready = 1'b1;
    tick();
    cpl_ready = 1'b0;
    jobs_model++;
    push_one(j);
    wait_launch(lat);
    tick();
    push_one(rand_job());
    tick();
    rst = 1'b1;
    #1;
    vectors++;
    if ({busy, arr_new_data, cpl_valid, cpl_overflow, cpl_timeout} !== 5'b0 ||
        {queue_count, jobs_done, cpl_cycles, arr_addr_C, cpl_addr_C} !== '0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b q=%0d jobs=%0d arrC=%h cplC=%h want all 0", busy, queue_count, jobs_done, arr_addr_C, cpl_addr_C);
    end
    @(negedge clk);
    rst = 1'b0;
    jobs_model = 0;
    mq.delete();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_abort();
    test_random();
    test_overflow_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
